// File: rtl/pattern_sequencer_pkg.sv
// Shared types and constants for the pattern sequencer.
package pattern_sequencer_pkg;

    // Sequencer states: steady output, waiting for a frame boundary,
    // holding the generator in reset, waiting for the video to settle.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_GRST   = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    // Pattern index = {smpte, range}
    localparam logic [1:0] FULL75   = 2'b00;
    localparam logic [1:0] FULL100  = 2'b01;
    localparam logic [1:0] SMPTE75  = 2'b10;
    localparam logic [1:0] SMPTE100 = 2'b11;

    localparam int unsigned SETTLE_FRAMES_DEF = 2;
    localparam int unsigned RST_CYCLES_DEF    = 4;
    localparam int unsigned FRAME_CNT_W       = 8;

    // Generator configuration; the low two bits form the pattern index.
    typedef struct packed {
        logic pal;
        logic scandouble;
        logic smpte;
        logic range;
    } vcfg_t;

    // Same timing standard, pattern index advanced by one (3 wraps to 0).
    function automatic vcfg_t next_pattern(input vcfg_t c);
        vcfg_t r;
        r = c;
        {r.smpte, r.range} = {c.smpte, c.range} + 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Host configuration request/acknowledge bundle.
interface pattern_sequencer_if;
    logic cfg_req;
    logic cfg_pal;
    logic cfg_range;
    logic cfg_smpte;
    logic cfg_scandouble;
    logic cfg_ack;

    modport master (
        output cfg_req, cfg_pal, cfg_range, cfg_smpte, cfg_scandouble,
        input  cfg_ack
    );

    modport slave (
        input  cfg_req, cfg_pal, cfg_range, cfg_smpte, cfg_scandouble,
        output cfg_ack
    );
endinterface

// File: rtl/pattern_sequencer_frame_counter.sv
// VSync rising-edge detector plus a clearable frame counter.
module frame_counter
    import pattern_sequencer_pkg::*;
#(
    parameter int unsigned W = FRAME_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         vsync_i,
    input  logic         enable_i,
    input  logic         clear_i,
    output logic         vs_rise_o,
    output logic [W-1:0] count_o
);

    logic         vs_prev_q;
    logic [W-1:0] count_q;

    assign vs_rise_o = vsync_i & ~vs_prev_q;
    assign count_o   = count_q;

    // Track previous vsync; count enabled rising edges, clear wins over count.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_prev_q <= 1'b0;
            count_q   <= '0;
        end else begin
            vs_prev_q <= vsync_i;
            if (clear_i) begin
                count_q <= '0;
            end else if (enable_i && vs_rise_o) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Sequences test-pattern / timing-standard changes into a video generator,
// applying them on frame boundaries and resetting/muting on timing changes.
module pattern_sequencer
    import pattern_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_FRAMES = SETTLE_FRAMES_DEF,
    parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    pattern_sequencer_if.slave  cfg,
    input  logic                next_pat,
    input  logic                auto_en,
    input  logic [7:0]          auto_frames,
    input  logic                vsync,
    output logic                pal,
    output logic                range,
    output logic                smpte,
    output logic                scandouble,
    output logic                gen_reset,
    output logic                mute,
    output logic                busy
);

    localparam logic [1:0] RUN    = ST_RUN;
    localparam logic [1:0] PEND   = ST_PEND;
    localparam logic [1:0] GRST   = ST_GRST;
    localparam logic [1:0] SETTLE = ST_SETTLE;

    localparam int unsigned SETTLE_N = (SETTLE_FRAMES == 0) ? 1 : SETTLE_FRAMES;
    localparam int unsigned RST_N    = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
    localparam int unsigned RC_W     = (RST_N > 1) ? $clog2(RST_N) : 1;

    logic [1:0]      state_q, state_d;
    vcfg_t           shadow_q, shadow_d;
    vcfg_t           out_q, out_d;
    logic            ack_q, ack_d;
    logic            ack_block_q, ack_block_d;
    logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
    logic            gen_reset_q, mute_q, busy_q;

    logic                   fc_enable, fc_clear, fc_rise;
    logic [FRAME_CNT_W-1:0] fc_count;
    logic [7:0]             auto_target;
    logic                   auto_hit, settle_hit;

    // One counter serves both auto cycling (in RUN) and settling (in SETTLE);
    // it is cleared on every state change so each use starts from zero.
    frame_counter #(.W(FRAME_CNT_W)) u_frame_counter (
        .clk       (clk),
        .reset     (reset),
        .vsync_i   (vsync),
        .enable_i  (fc_enable),
        .clear_i   (fc_clear),
        .vs_rise_o (fc_rise),
        .count_o   (fc_count)
    );

    assign auto_target = (auto_frames == 8'd0) ? 8'd1 : auto_frames;
    assign auto_hit    = auto_en && fc_rise &&
                         (({1'b0, fc_count} + 9'd1) >= {1'b0, auto_target});
    assign settle_hit  = fc_rise && (({1'b0, fc_count} + 9'd1) >= 9'(SETTLE_N));

    // Next-state logic for the sequencer and its shadow/applied configuration.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        ack_d       = 1'b0;
        ack_block_d = ack_block_q & cfg.cfg_req;
        rst_cnt_d   = rst_cnt_q;
        fc_enable   = 1'b0;
        fc_clear    = 1'b0;
        case (state_q)
            RUN: begin
                fc_enable = auto_en;
                if (cfg.cfg_req && !ack_block_q) begin
                    shadow_d    = {cfg.cfg_pal, cfg.cfg_scandouble,
                                   cfg.cfg_smpte, cfg.cfg_range};
                    ack_d       = 1'b1;
                    ack_block_d = 1'b1;
                    state_d     = PEND;
                    fc_clear    = 1'b1;
                end else if (next_pat || auto_hit) begin
                    shadow_d = next_pattern(out_q);
                    state_d  = PEND;
                    fc_clear = 1'b1;
                end else if (!auto_en) begin
                    fc_clear = 1'b1;
                end
            end
            PEND: begin
                if (fc_rise) begin
                    out_d = shadow_q;
                    if ((shadow_q.pal != out_q.pal) ||
                        (shadow_q.scandouble != out_q.scandouble)) begin
                        state_d   = GRST;
                        rst_cnt_d = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            GRST: begin
                if (rst_cnt_q == RC_W'(RST_N - 1)) begin
                    state_d  = SETTLE;
                    fc_clear = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                fc_enable = 1'b1;
                if (settle_hit) begin
                    state_d  = RUN;
                    fc_clear = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State and registered outputs; status outputs decode the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            shadow_q    <= '0;
            out_q       <= '0;
            ack_q       <= 1'b0;
            ack_block_q <= 1'b0;
            rst_cnt_q   <= '0;
            gen_reset_q <= 1'b1;
            mute_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            ack_q       <= ack_d;
            ack_block_q <= ack_block_d;
            rst_cnt_q   <= rst_cnt_d;
            gen_reset_q <= (state_d == GRST);
            mute_q      <= (state_d == GRST) || (state_d == SETTLE);
            busy_q      <= (state_d != RUN);
        end
    end

    assign cfg.cfg_ack = ack_q;
    assign pal         = out_q.pal;
    assign scandouble  = out_q.scandouble;
    assign smpte       = out_q.smpte;
    assign range       = out_q.range;
    assign gen_reset   = gen_reset_q;
    assign mute        = mute_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: directed scenarios plus a
// randomized run against a frame-level behavioural model.
module tb_pattern_sequencer;

    localparam int unsigned SF = 2;
    localparam int unsigned RC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       next_pat;
    logic       auto_en;
    logic [7:0] auto_frames;
    logic       vsync;
    logic       pal, range, smpte, scandouble, gen_reset, mute, busy;

    pattern_sequencer_if bus ();

    pattern_sequencer #(.SETTLE_FRAMES(SF), .RST_CYCLES(RC)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (bus),
        .next_pat    (next_pat),
        .auto_en     (auto_en),
        .auto_frames (auto_frames),
        .vsync       (vsync),
        .pal         (pal),
        .range       (range),
        .smpte       (smpte),
        .scandouble  (scandouble),
        .gen_reset   (gen_reset),
        .mute        (mute),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: applied config, staged request, and how many reset
    // cycles / settle frames remain before video is live again.
    bit m_pal, m_scan;
    int m_idx;
    bit s_pal, s_scan;
    int s_idx;
    bit m_pending;
    int m_rst_left;
    int m_settle_left;
    int m_auto;
    bit m_blocked;
    bit m_prev_vs;
    bit m_ack;
    bit m_gen;

    task model_step;
        bit rise, idle, hit;
        int tgt;
        bit changed;
        rise = vsync && !m_prev_vs;
        m_prev_vs = vsync;
        if (reset) begin
            m_pal = 0; m_scan = 0; m_idx = 0;
            s_pal = 0; s_scan = 0; s_idx = 0;
            m_pending = 0; m_rst_left = 0; m_settle_left = 0;
            m_auto = 0; m_blocked = 0; m_ack = 0; m_gen = 1;
        end else begin
            m_ack = 0;
            idle = !m_pending && m_rst_left == 0 && m_settle_left == 0;
            if (idle) begin
                tgt = (auto_frames == 0) ? 1 : int'(auto_frames);
                hit = auto_en && rise && (m_auto + 1 >= tgt);
                if (bus.cfg_req && !m_blocked) begin
                    s_pal = bus.cfg_pal; s_scan = bus.cfg_scandouble;
                    s_idx = 2 * int'(bus.cfg_smpte) + int'(bus.cfg_range);
                    m_ack = 1; m_blocked = 1; m_pending = 1; m_auto = 0;
                end else if (next_pat || hit) begin
                    s_pal = m_pal; s_scan = m_scan; s_idx = (m_idx + 1) % 4;
                    m_pending = 1; m_auto = 0;
                end else if (!auto_en) begin
                    m_auto = 0;
                end else if (rise) begin
                    m_auto++;
                end
            end else begin
                m_auto = 0;
                if (m_pending) begin
                    if (rise) begin
                        changed = (s_pal != m_pal) || (s_scan != m_scan);
                        m_pal = s_pal; m_scan = s_scan; m_idx = s_idx;
                        m_pending = 0;
                        if (changed) m_rst_left = RC;
                    end
                end else if (m_rst_left > 0) begin
                    m_rst_left--;
                    if (m_rst_left == 0) m_settle_left = SF;
                end else if (rise) begin
                    m_settle_left--;
                end
            end
            if (!bus.cfg_req) m_blocked = 0;
            m_gen = (m_rst_left > 0);
        end
    endtask

    function automatic logic [7:0] exp_vec();
        bit mu;
        mu = (m_rst_left > 0) || (m_settle_left > 0);
        return {m_pal, m_scan, 2'(m_idx), m_ack, m_gen, mu, m_pending || mu};
    endfunction

    // [7]pal [6]scandouble [5]smpte [4]range [3]cfg_ack [2]gen_reset [1]mute [0]busy
    function automatic logic [7:0] outs();
        return {pal, scandouble, smpte, range, bus.cfg_ack, gen_reset, mute, busy};
    endfunction

    task tick;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task vs_edge;
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task set_req(input bit p, input bit s, input bit sm, input bit r);
        bus.cfg_req = 1'b1;
        bus.cfg_pal = p; bus.cfg_scandouble = s;
        bus.cfg_smpte = sm; bus.cfg_range = r;
    endtask

    task test_reset;
        reset = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 8'b0000_0100) begin
            n_fail++; $display("FAIL reset_state: got %b expected %b", outs(), 8'b0000_0100);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (outs() !== 8'b0000_0000) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", outs(), 8'b0000_0000);
        end
    endtask

    task test_pattern_cfg;
        set_req(0, 0, 1, 0);
        tick();
        n_tests++;
        if (outs() !== 8'b0000_1001) begin
            n_fail++; $display("FAIL pat_ack: got %b expected %b", outs(), 8'b0000_1001);
        end
        bus.cfg_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (outs() !== 8'b0000_0001) begin
                n_fail++; $display("FAIL pat_pending: got %b expected %b", outs(), 8'b0000_0001);
            end
        end
        vs_edge();
        n_tests++;
        if (outs() !== 8'b0010_0000) begin
            n_fail++; $display("FAIL pat_applied: got %b expected %b", outs(), 8'b0010_0000);
        end
    endtask

    task test_pal_change;
        int cycles;
        set_req(1, 0, 1, 0);
        tick();
        n_tests++;
        if (outs() !== 8'b0010_1001) begin
            n_fail++; $display("FAIL pal_ack: got %b expected %b", outs(), 8'b0010_1001);
        end
        bus.cfg_req = 1'b0;
        vs_edge();
        n_tests++;
        if (outs() !== 8'b1010_0111) begin
            n_fail++; $display("FAIL pal_grst_entry: got %b expected %b", outs(), 8'b1010_0111);
        end
        cycles = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gen_reset) cycles++;
            else break;
        end
        n_tests++;
        if (cycles != RC) begin
            n_fail++; $display("FAIL pal_grst_len: got %0d cycles expected %0d", cycles, RC);
        end
        n_tests++;
        if (outs() !== 8'b1010_0011) begin
            n_fail++; $display("FAIL pal_settle: got %b expected %b", outs(), 8'b1010_0011);
        end
        vs_edge();
        n_tests++;
        if (outs() !== 8'b1010_0011) begin
            n_fail++; $display("FAIL pal_settle_edge1: got %b expected %b", outs(), 8'b1010_0011);
        end
        vs_edge();
        n_tests++;
        if (outs() !== 8'b1010_0000) begin
            n_fail++; $display("FAIL pal_unmute: got %b expected %b", outs(), 8'b1010_0000);
        end
    endtask

    task test_auto;
        set_req(1, 0, 1, 1);
        tick();
        bus.cfg_req = 1'b0;
        vs_edge();
        n_tests++;
        if (outs() !== 8'b1011_0000) begin
            n_fail++; $display("FAIL auto_setup: got %b expected %b", outs(), 8'b1011_0000);
        end
        auto_en = 1'b1;
        auto_frames = 8'd3;
        for (int i = 1; i <= 2; i++) begin
            vs_edge();
            n_tests++;
            if (outs() !== 8'b1011_0000) begin
                n_fail++; $display("FAIL auto_wait%0d: got %b expected %b", i, outs(), 8'b1011_0000);
            end
        end
        vs_edge();
        n_tests++;
        if (outs() !== 8'b1011_0001) begin
            n_fail++; $display("FAIL auto_step: got %b expected %b", outs(), 8'b1011_0001);
        end
        vs_edge();
        n_tests++;
        if (outs() !== 8'b1000_0000) begin
            n_fail++; $display("FAIL auto_wrap: got %b expected %b", outs(), 8'b1000_0000);
        end
        auto_en = 1'b0;
        tick();
    endtask

    task test_priority;
        set_req(1, 0, 1, 0);
        next_pat = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 8'b1000_1001) begin
            n_fail++; $display("FAIL prio_ack: got %b expected %b", outs(), 8'b1000_1001);
        end
        bus.cfg_req = 1'b0;
        next_pat = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vs_edge();
            n_tests++;
            if (outs() !== 8'b1010_0000) begin
                n_fail++; $display("FAIL prio_applied%0d: got %b expected %b", i, outs(), 8'b1010_0000);
            end
        end
    endtask

    task test_reset_in_settle;
        set_req(0, 1, 1, 1);
        tick();
        bus.cfg_req = 1'b0;
        vs_edge();
        for (int i = 0; i < 20; i++) begin
            if (!gen_reset) break;
            tick();
        end
        n_tests++;
        if (outs() !== 8'b0111_0011) begin
            n_fail++; $display("FAIL rst_mid_settle: got %b expected %b", outs(), 8'b0111_0011);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (outs() !== 8'b0000_0100) begin
            n_fail++; $display("FAIL rst_abort: got %b expected %b", outs(), 8'b0000_0100);
        end
        reset = 1'b0;
        tick();
        vs_edge();
        n_tests++;
        if (outs() !== 8'b0000_0000) begin
            n_fail++; $display("FAIL rst_after: got %b expected %b", outs(), 8'b0000_0000);
        end
    endtask

    task test_ack_hold;
        int acks;
        acks = 0;
        set_req(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            acks += int'(bus.cfg_ack);
        end
        n_tests++;
        if (acks != 1) begin
            n_fail++; $display("FAIL hold_one_ack: got %0d acks expected 1", acks);
        end
        vsync = 1'b0;
        tick();
        acks += int'(bus.cfg_ack);
        vsync = 1'b1;
        tick();
        acks += int'(bus.cfg_ack);
        vsync = 1'b0;
        n_tests++;
        if (outs() !== 8'b0010_0000) begin
            n_fail++; $display("FAIL hold_run: got %b expected %b", outs(), 8'b0010_0000);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(bus.cfg_ack);
        end
        n_tests++;
        if (acks != 1) begin
            n_fail++; $display("FAIL hold_no_reack: got %0d acks expected 1", acks);
        end
        bus.cfg_req = 1'b0;
        tick();
        set_req(0, 0, 1, 1);
        tick();
        n_tests++;
        if (outs() !== 8'b0010_1001) begin
            n_fail++; $display("FAIL hold_reack: got %b expected %b", outs(), 8'b0010_1001);
        end
        bus.cfg_req = 1'b0;
        tick();
        n_tests++;
        if (outs() !== 8'b0010_0001) begin
            n_fail++; $display("FAIL hold_ack_pulse: got %b expected %b", outs(), 8'b0010_0001);
        end
        vs_edge();
        n_tests++;
        if (outs() !== 8'b0011_0000) begin
            n_fail++; $display("FAIL hold_applied: got %b expected %b", outs(), 8'b0011_0000);
        end
    endtask

    task test_random;
        int rfails;
        rfails = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            if (bus.cfg_req) bus.cfg_req = ($urandom_range(0, 3) != 0);
            else             bus.cfg_req = ($urandom_range(0, 9) == 0);
            bus.cfg_pal        = 1'($urandom_range(0, 1));
            bus.cfg_scandouble = ($urandom_range(0, 3) == 0);
            bus.cfg_smpte      = 1'($urandom_range(0, 1));
            bus.cfg_range      = 1'($urandom_range(0, 1));
            next_pat = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 99) == 0) auto_frames = 8'($urandom_range(0, 3));
            vsync = ($urandom_range(0, 4) == 0);
            tick();
            n_tests++;
            if (outs() !== exp_vec()) begin
                n_fail++;
                rfails++;
                if (rfails <= 10)
                    $display("FAIL random_cycle%0d: got %b expected %b", i, outs(), exp_vec());
            end
        end
        reset = 1'b0; bus.cfg_req = 1'b0; next_pat = 1'b0; auto_en = 1'b0; vsync = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        next_pat = 1'b0;
        auto_en = 1'b0;
        auto_frames = 8'd1;
        vsync = 1'b0;
        bus.cfg_req = 1'b0;
        bus.cfg_pal = 1'b0;
        bus.cfg_range = 1'b0;
        bus.cfg_smpte = 1'b0;
        bus.cfg_scandouble = 1'b0;
        test_reset();
        test_pattern_cfg();
        test_pal_change();
        test_auto();
        test_priority();
        test_reset_in_settle();
        test_ack_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
